// File: rtl/riscv_pipe_pkg.sv
// riscv_pipe_pkg: shared pipeline control encoding for the decode/execute boundary.
package riscv_pipe_pkg;
    typedef struct packed {
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       branch;
        logic       alusrc;
        logic [1:0] aluop;
    } ctrl_t;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

    localparam ctrl_t BUBBLE_CTRL = '0;
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags a load in EX whose destination is read by the instruction in ID.
module load_use_detect #(
    parameter int REG_AW = 5
) (
    input  logic              ex_valid,
    input  logic              ex_memread,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              id_valid,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    output logic              hazard_stall
);
    assign hazard_stall = ex_valid && ex_memread && (ex_rd != '0) && id_valid &&
                          ((id_uses_rs1 && ex_rd == id_rs1) || (id_uses_rs2 && ex_rd == id_rs2));
endmodule

// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg: ID/EX pipeline register with load-use bubbling, flush and hold.
// Define ID_WB_BYPASS_EN to forward same-cycle writeback data into the captured operands.
module id_ex_stage_reg
    import riscv_pipe_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic [XLEN-1:0]   id_rdata1,
    input  logic [XLEN-1:0]   id_rdata2,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [3:0]        id_funct,
    input  logic [7:0]        id_ctrl,
    input  logic              flush,
    input  logic              hold,
    input  logic              wb_regwrite,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic              hazard_stall,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_rdata1,
    output logic [XLEN-1:0]   ex_rdata2,
    output logic [XLEN-1:0]   ex_imm,
    output logic [REG_AW-1:0] ex_rs1,
    output logic [REG_AW-1:0] ex_rs2,
    output logic [REG_AW-1:0] ex_rd,
    output logic [3:0]        ex_funct,
    output logic [7:0]        ex_ctrl
);
    ctrl_t ex_c;
    logic  bubble, byp1, byp2;

    assign ex_ctrl = ex_c;

    load_use_detect #(.REG_AW(REG_AW)) u_load_use_detect (
        .ex_valid     (ex_valid),
        .ex_memread   (ex_c.memread),
        .ex_rd        (ex_rd),
        .id_valid     (id_valid),
        .id_uses_rs1  (id_uses_rs1),
        .id_uses_rs2  (id_uses_rs2),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .hazard_stall (hazard_stall)
    );

    // An invalid ID slot is captured as a bubble so forwarding never matches it.
    assign bubble = flush || (!hold && (hazard_stall || !id_valid));

`ifdef ID_WB_BYPASS_EN
    assign byp1 = wb_regwrite && wb_rd != '0 && wb_rd == id_rs1;
    assign byp2 = wb_regwrite && wb_rd != '0 && wb_rd == id_rs2;
`else
    logic unused_wb;
    assign unused_wb = ^{wb_regwrite, wb_rd, wb_data};
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid  <= 1'b0;
            ex_pc     <= '0;
            ex_rdata1 <= '0;
            ex_rdata2 <= '0;
            ex_imm    <= '0;
            ex_rs1    <= '0;
            ex_rs2    <= '0;
            ex_rd     <= '0;
            ex_funct  <= '0;
            ex_c      <= BUBBLE_CTRL;
        end else if (bubble) begin
            ex_valid  <= 1'b0;
            ex_pc     <= '0;
            ex_rdata1 <= '0;
            ex_rdata2 <= '0;
            ex_imm    <= '0;
            ex_rs1    <= '0;
            ex_rs2    <= '0;
            ex_rd     <= '0;
            ex_funct  <= '0;
            ex_c      <= BUBBLE_CTRL;
        end else if (!hold) begin
            ex_valid  <= 1'b1;
            ex_pc     <= id_pc;
            ex_rdata1 <= byp1 ? wb_data : id_rdata1;
            ex_rdata2 <= byp2 ? wb_data : id_rdata2;
            ex_imm    <= id_imm;
            ex_rs1    <= id_rs1;
            ex_rs2    <= id_rs2;
            ex_rd     <= id_rd;
            ex_funct  <= id_funct;
            ex_c      <= ctrl_t'(id_ctrl);
        end
    end
endmodule

// File: tb/tb_id_ex_stage_reg.sv
// tb_id_ex_stage_reg: directed-vector bench with a per-cycle reference model of the ID/EX register.
module tb_id_ex_stage_reg;
    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid, id_uses_rs1, id_uses_rs2, flush, hold, wb_regwrite;
    logic [31:0] id_pc, id_rdata1, id_rdata2, id_imm, wb_data;
    logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd;
    logic [3:0]  id_funct;
    logic [7:0]  id_ctrl;
    logic        hazard_stall, ex_valid;
    logic [31:0] ex_pc, ex_rdata1, ex_rdata2, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [3:0]  ex_funct;
    logic [7:0]  ex_ctrl;

    typedef struct packed {
        logic        v;
        logic [31:0] pc, r1, r2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  funct;
        logic [7:0]  ctrl;
    } ent_t;

    localparam logic [7:0] C_LW  = 8'b1101_0100;
    localparam logic [7:0] C_ADD = 8'b1000_0010;
    localparam logic [7:0] C_LUI = 8'b1000_0100;
`ifdef ID_WB_BYPASS_EN
    localparam logic [31:0] BYP_EXP = 32'hDEADBEEF;
`else
    localparam logic [31:0] BYP_EXP = 32'h0;
`endif

    ent_t m;
    ent_t dut_e;
    int   checks = 0;
    int   failures = 0;

    assign dut_e = {ex_valid, ex_pc, ex_rdata1, ex_rdata2, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct, ex_ctrl};

    id_ex_stage_reg #(.XLEN(32), .REG_AW(5)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
        .id_funct(id_funct), .id_ctrl(id_ctrl), .flush(flush), .hold(hold),
        .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
        .hazard_stall(hazard_stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_funct(ex_funct), .ex_ctrl(ex_ctrl)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [159:0] got, input logic [159:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    // A load in EX (memread is ctrl bit 6) writing a nonzero register read by ID.
    function automatic logic model_hz();
        return m.v && m.ctrl[6] && m.rd != 0 && id_valid &&
               ((id_uses_rs1 && m.rd == id_rs1) || (id_uses_rs2 && m.rd == id_rs2));
    endfunction

    function automatic logic [31:0] operand(input logic [4:0] rs, input logic [31:0] rf);
`ifdef ID_WB_BYPASS_EN
        if (wb_regwrite && wb_rd != 0 && wb_rd == rs) return wb_data;
`endif
        return rf;
    endfunction

    function automatic ent_t model_next();
        ent_t n = '0;
        if (flush) return n;
        if (hold) return m;
        if (model_hz() || !id_valid) return n;
        n.v = 1'b1;
        n.pc = id_pc;
        n.r1 = operand(id_rs1, id_rdata1);
        n.r2 = operand(id_rs2, id_rdata2);
        n.imm = id_imm;
        n.rs1 = id_rs1;
        n.rs2 = id_rs2;
        n.rd = id_rd;
        n.funct = id_funct;
        n.ctrl = id_ctrl;
        return n;
    endfunction

    // Entered at posedge+1; checks the stall line, advances model on the edge, checks EX state.
    task automatic cyc();
        #1 chk("hazard_stall", hazard_stall, model_hz());
        @(posedge clk);
        m = model_next();
        #1 chk("ex_state", dut_e, m);
    endtask

    task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rs1, rs2, rd,
                          input logic u1, u2, input logic [31:0] r1, r2, imm,
                          input logic [3:0] fn, input logic [7:0] ctl);
        id_valid = v; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_uses_rs1 = u1; id_uses_rs2 = u2; id_rdata1 = r1; id_rdata2 = r2;
        id_imm = imm; id_funct = fn; id_ctrl = ctl;
    endtask

    initial begin
        reset = 1'b1; flush = 0; hold = 0; wb_regwrite = 0; wb_rd = 0; wb_data = 0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        m = '0;
        @(posedge clk);
        @(posedge clk);
        #1 chk("reset_state", dut_e, 0);
        chk("reset_stall", hazard_stall, 0);
        reset = 1'b0;

        // lw x5, 4(x2)
        set_id(1, 32'h100, 2, 0, 5, 1, 0, 32'h1000, 0, 4, 4'b0010, C_LW);
        cyc();
        chk("lw_captured_rd", ex_rd, 5);
        // add x6, x5, x7 -> one bubble, then captured
        set_id(1, 32'h104, 5, 7, 6, 1, 1, 32'h11, 32'h22, 0, 4'b0000, C_ADD);
        #1 chk("load_use_stall", hazard_stall, 1);
        cyc();
        chk("bubble_valid", ex_valid, 0);
        chk("bubble_ctrl", ex_ctrl, 0);
        #1 chk("stall_released", hazard_stall, 0);
        cyc();
        chk("dep_captured_rs1", ex_rs1, 5);
        chk("dep_captured_pc", ex_pc, 32'h104);

        // No false stall: rs1 matches but unused
        set_id(1, 32'h108, 2, 0, 5, 1, 0, 32'h2000, 0, 8, 4'b0010, C_LW);
        cyc();
        set_id(1, 32'h10C, 5, 5, 9, 0, 0, 0, 0, 32'h5000, 4'b0000, C_LUI);
        #1 chk("unused_rs_no_stall", hazard_stall, 0);
        cyc();
        chk("unused_rs_captured", ex_pc, 32'h10C);
        // Load into x0 never stalls
        set_id(1, 32'h110, 2, 0, 0, 1, 0, 32'h3000, 0, 0, 4'b0010, C_LW);
        cyc();
        set_id(1, 32'h114, 0, 0, 8, 1, 1, 0, 0, 0, 4'b0000, C_ADD);
        #1 chk("x0_no_stall", hazard_stall, 0);
        cyc();
        chk("x0_dep_captured", ex_pc, 32'h114);

        // Flush beats hold
        flush = 1; hold = 1;
        cyc();
        chk("flush_valid", ex_valid, 0);
        chk("flush_ctrl_rd", {ex_ctrl, ex_rd}, 0);
        flush = 0; hold = 0;

        // Hold for three cycles while ID changes
        set_id(1, 32'h200, 1, 2, 3, 1, 1, 32'hA, 32'hB, 32'hC, 4'b1000, C_ADD);
        cyc();
        hold = 1;
        for (int i = 0; i < 3; i++) begin
            set_id(1, 32'h300 + 4 * i, 4, 5, 6, 1, 1, 32'h1 + i, 32'h2, 32'h3, 4'b0001, C_LUI);
            cyc();
        end
        chk("hold_pc", ex_pc, 32'h200);
        chk("hold_rd", ex_rd, 3);
        hold = 0;
        cyc();
        chk("release_pc", ex_pc, 32'h308);

        // Hold over a load-use pair: stall still reported, load stays in EX
        set_id(1, 32'h400, 2, 0, 7, 1, 0, 32'h4000, 0, 0, 4'b0010, C_LW);
        cyc();
        set_id(1, 32'h404, 3, 7, 8, 1, 1, 0, 0, 0, 4'b0000, C_ADD);
        hold = 1;
        #1 chk("stall_under_hold", hazard_stall, 1);
        cyc();
        chk("held_load_pc", ex_pc, 32'h400);
        hold = 0;
        cyc();
        cyc();
        chk("dep_after_hold", ex_pc, 32'h404);

        // Writeback bypass into rs2 (and not through x0)
        wb_regwrite = 1; wb_rd = 3; wb_data = 32'hDEADBEEF;
        set_id(1, 32'h500, 1, 3, 4, 1, 1, 32'h77, 32'h0, 0, 4'b0000, C_ADD);
        cyc();
        chk("bypass_rdata2", ex_rdata2, BYP_EXP);
        chk("bypass_rdata1_untouched", ex_rdata1, 32'h77);
        wb_rd = 0;
        set_id(1, 32'h504, 0, 0, 4, 1, 1, 32'h0, 32'h0, 0, 4'b0000, C_ADD);
        cyc();
        chk("bypass_x0_ignored", ex_rdata1, 0);
        wb_regwrite = 0;

        // Invalid ID slot captured as a bubble
        set_id(0, 32'h600, 1, 2, 3, 1, 1, 32'h9, 32'h9, 32'h9, 4'b1111, C_ADD);
        cyc();
        chk("invalid_slot", {ex_valid, ex_rd, ex_ctrl, ex_pc}, 0);

        // Reset asserted mid-stall clears asynchronously
        set_id(1, 32'h700, 2, 0, 5, 1, 0, 32'h1, 0, 0, 4'b0010, C_LW);
        cyc();
        set_id(1, 32'h704, 5, 0, 6, 1, 0, 0, 0, 0, 4'b0000, C_ADD);
        #1 chk("pre_reset_stall", hazard_stall, 1);
        #1 reset = 1;
        #1 chk("async_reset_state", dut_e, 0);
        chk("async_reset_stall", hazard_stall, 0);
        m = '0;
        @(posedge clk);
        #1 reset = 0;
        cyc();
        chk("post_reset_capture", ex_pc, 32'h704);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
